mc_alu: RTL and testbench

//  Parametrised multi-cycle ALU. Successor to the CPU's single-cycle ALU and the 8/4 7-seg divider.

---
 rtl/mc_alu_pkg.sv | 18 +
 rtl/mc_alu_iter.sv | 64 ++++++
 rtl/mc_alu.sv | 118 +++++++++++
 tb/tb_mc_alu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_alu_pkg.sv
// mc_alu_pkg: opcodes, FSM states and default word width shared by the multi-cycle ALU.
package mc_alu_pkg;
   localparam int DEF_WIDTH = 32;
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_AND  = 4'h1;
   localparam logic [3:0] OP_OR   = 4'h2;
   localparam logic [3:0] OP_XOR  = 4'h3;
   localparam logic [3:0] OP_ADDS = 4'h4;
   localparam logic [3:0] OP_ADDU = 4'h5;
   localparam logic [3:0] OP_SUBS = 4'h6;
   localparam logic [3:0] OP_SUBU = 4'h7;
   localparam logic [3:0] OP_SHRL = 4'h8;
   localparam logic [3:0] OP_SHLL = 4'h9;
   localparam logic [3:0] OP_MULU = 4'hA;
   localparam logic [3:0] OP_DIVU = 4'hB;
   localparam logic [3:0] OP_REMU = 4'hC;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
endpackage

// File: rtl/mc_alu_iter.sv
// mc_alu_iter: shared shift-add multiplier / restoring divider, one step per cycle.
// The start cycle already performs the first step on the incoming operands.
module mc_alu_iter
   import mc_alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_fin,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_quo,
   output logic [WIDTH-1:0] o_rem
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] r_acc, r_q, r_m, w_acc, w_q, w_m, w_acc_n, w_q_n;
   logic [WIDTH:0]   w_add, w_shl, w_sub;
   logic             r_div, w_div;
   logic [CNT_W-1:0] r_cnt;

   assign w_acc = i_start ? '0 : r_acc;
   assign w_q   = i_start ? i_a : r_q;
   assign w_m   = i_start ? i_b : r_m;
   assign w_div = i_start ? i_div : r_div;

   // mul: acc:q shifts right with conditional add; div: acc:q shifts left, trial-subtract divisor
   assign w_add   = {1'b0, w_acc} + {1'b0, (w_q[0] ? w_m : {WIDTH{1'b0}})};
   assign w_shl   = {w_acc, w_q[WIDTH-1]};
   assign w_sub   = w_shl - {1'b0, w_m};
   assign w_acc_n = w_div ? (w_sub[WIDTH] ? w_shl[WIDTH-1:0] : w_sub[WIDTH-1:0]) : w_add[WIDTH:1];
   assign w_q_n   = w_div ? {w_q[WIDTH-2:0], ~w_sub[WIDTH]} : {w_add[0], w_q[WIDTH-1:1]};

   assign o_fin = r_cnt == CNT_W'(1);
   assign o_hi  = w_acc_n;
   assign o_lo  = w_q_n;
   assign o_quo = w_q_n;
   assign o_rem = w_acc_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc <= '0;
         r_q   <= '0;
         r_m   <= '0;
         r_div <= 1'b0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_acc <= w_acc_n;
         r_q   <= w_q_n;
         r_m   <= i_b;
         r_div <= i_div;
         r_cnt <= CNT_W'(WIDTH - 1);
      end else if (r_cnt != '0) begin
         r_acc <= w_acc_n;
         r_q   <= w_q_n;
         r_cnt <= r_cnt - 1'b1;
      end
   end
endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with valid/ready request and response handshakes.
// Single-cycle ops and divide-by-zero answer in one cycle; MULU/DIVU/REMU take WIDTH cycles.
module mc_alu
   import mc_alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in_0,
   input  logic [WIDTH-1:0] in_1,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] out,
   output logic             of,
   output logic             dz
);
   localparam int SHAMT_W = $clog2(WIDTH);
   localparam int MSB     = WIDTH - 1;

   state_e             r_state, w_next;
   logic [3:0]         r_op;
   logic [WIDTH-1:0]   r_out, w_res, w_sum, w_dif, w_hi, w_lo, w_quo, w_rem;
   logic               r_of, r_dz, w_of, w_dz, w_acc, w_start, w_fin, w_div_op, w_zero;
   logic [SHAMT_W-1:0] w_sh;

   assign req_ready = r_state == S_IDLE;
   assign rsp_valid = r_state == S_DONE;
   assign out       = r_out;
   assign of        = r_of;
   assign dz        = r_dz;

   assign w_acc    = req_valid & req_ready;
   assign w_div_op = (op == OP_DIVU) | (op == OP_REMU);
   assign w_zero   = in_1 == '0;
   assign w_start  = w_acc & ((op == OP_MULU) | (w_div_op & ~w_zero));
   assign w_dz     = w_div_op & w_zero;
   assign w_sum    = in_0 + in_1;
   assign w_dif    = in_0 - in_1;
   assign w_sh     = in_1[SHAMT_W-1:0];

   // divide by zero lands here too: DIVU gives all-ones, REMU passes the dividend
   always_comb begin
      w_res = in_0;
      w_of  = 1'b0;
      case (op)
         OP_AND:  w_res = in_0 & in_1;
         OP_OR:   w_res = in_0 | in_1;
         OP_XOR:  w_res = in_0 ^ in_1;
         OP_ADDS: begin
            w_res = w_sum;
            w_of  = (in_0[MSB] == in_1[MSB]) & (w_sum[MSB] != in_0[MSB]);
         end
         OP_ADDU: w_res = w_sum;
         OP_SUBS: begin
            w_res = w_dif;
            w_of  = (in_0[MSB] != in_1[MSB]) & (w_dif[MSB] != in_0[MSB]);
         end
         OP_SUBU: w_res = w_dif;
         OP_SHRL: w_res = in_0 >> w_sh;
         OP_SHLL: w_res = in_0 << w_sh;
         OP_DIVU: w_res = '1;
         default: ;
      endcase
   end

   mc_alu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_start),
      .i_div   (op != OP_MULU),
      .i_a     (in_0),
      .i_b     (in_1),
      .o_fin   (w_fin),
      .o_hi    (w_hi),
      .o_lo    (w_lo),
      .o_quo   (w_quo),
      .o_rem   (w_rem)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_acc) w_next = w_start ? S_CALC : S_DONE;
         S_CALC:  if (w_fin) w_next = S_DONE;
         S_DONE:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op  <= OP_NOP;
         r_out <= '0;
         r_of  <= 1'b0;
         r_dz  <= 1'b0;
      end else begin
         if (w_acc) r_op <= op;
         if (w_acc & ~w_start) begin
            r_out <= w_res;
            r_of  <= w_of;
            r_dz  <= w_dz;
         end else if ((r_state == S_CALC) & w_fin) begin
            r_out <= (r_op == OP_MULU) ? w_lo : (r_op == OP_DIVU) ? w_quo : w_rem;
            r_of  <= (r_op == OP_MULU) & (|w_hi);
            r_dz  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: random and directed requests to 32- and 8-bit mc_alu instances,
// expected responses queued at accept time and checked by per-instance monitors.
module tb_mc_alu;
   typedef struct {
      logic [31:0] out;
      logic        of;
      logic        dz;
      int          lat;
      int          acc_cyc;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b0;
   logic        rv32 = 1'b0, rr32, rsv32, rsr32, of32, dz32;
   logic [3:0]  op32 = '0;
   logic [31:0] a32 = '0, b32 = '0, o32;
   logic        rv8 = 1'b0, rr8, rsv8, rsr8, of8, dz8;
   logic [3:0]  op8 = '0;
   logic [7:0]  a8 = '0, b8 = '0, o8;

   exp_t q32[$], q8[$];
   exp_t cur[2];
   logic seen[2];
   int   checks = 0, errors = 0, cyc = 0, rm32 = 0;

   mc_alu #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .req_valid(rv32), .req_ready(rr32), .op(op32), .in_0(a32), .in_1(b32),
      .rsp_valid(rsv32), .rsp_ready(rsr32), .out(o32), .of(of32), .dz(dz32));

   mc_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .req_valid(rv8), .req_ready(rr8), .op(op8), .in_0(a8), .in_1(b8),
      .rsp_valid(rsv8), .rsp_ready(rsr8), .out(o8), .of(of8), .dz(dz8));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int w);
      exp_t e;
      logic [63:0] m, x, y, r, p;
      int sh;
      m = (64'd1 << w) - 64'd1;
      x = {32'b0, a} & m;
      y = {32'b0, b} & m;
      sh = int'(y % 64'(w));
      r = x;
      e.of = 1'b0;
      e.dz = 1'b0;
      e.lat = 1;
      e.acc_cyc = 0;
      case (op)
         4'h1: r = x & y;
         4'h2: r = x | y;
         4'h3: r = x ^ y;
         4'h4, 4'h5: r = (x + y) & m;
         4'h6, 4'h7: r = (x - y) & m;
         4'h8: r = x >> sh;
         4'h9: r = (x << sh) & m;
         4'hA: begin
            p = x * y;
            r = p & m;
            e.of = (p >> w) != 0;
            e.lat = w;
         end
         4'hB, 4'hC: begin
            if (y == 0) begin
               e.dz = 1'b1;
               r = (op == 4'hB) ? m : x;
            end else begin
               r = (op == 4'hB) ? x / y : x % y;
               e.lat = w;
            end
         end
         default: r = x;
      endcase
      if (op == 4'h4) e.of = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
      if (op == 4'h6) e.of = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
      e.out = r[31:0];
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic mon(input int idx, input logic rsv, input logic rsr, input logic rr,
                      input logic [31:0] o, input logic of_v, input logic dz_v);
      string p;
      p = (idx == 0) ? "w32" : "w8";
      if (rsv) begin
         chk({p, "_req_ready_busy"}, 64'(rr), 64'd0);
         if (!seen[idx]) begin
            if ((idx == 0 ? q32.size() : q8.size()) == 0) begin
               checks++;
               errors++;
               $display("FAIL %s_unexpected_rsp: got out=%0h with no pending request", p, o);
            end else begin
               cur[idx] = (idx == 0) ? q32.pop_front() : q8.pop_front();
               seen[idx] = 1'b1;
               chk({p, "_out"}, 64'(o), 64'(cur[idx].out));
               chk({p, "_of"}, 64'(of_v), 64'(cur[idx].of));
               chk({p, "_dz"}, 64'(dz_v), 64'(cur[idx].dz));
               chk({p, "_latency"}, 64'(cyc - cur[idx].acc_cyc + 1), 64'(cur[idx].lat));
            end
         end else begin
            chk({p, "_hold_out"}, 64'(o), 64'(cur[idx].out));
            chk({p, "_hold_flags"}, {62'b0, of_v, dz_v}, {62'b0, cur[idx].of, cur[idx].dz});
         end
         if (rsr) seen[idx] = 1'b0;
      end
   endtask

   always @(negedge clk) if (rst) mon(0, rsv32, rsr32, rr32, o32, of32, dz32);
   always @(negedge clk) if (rst) mon(1, rsv8, rsr8, rr8, {24'b0, o8}, of8, dz8);

   initial begin
      rsr32 = 1'b0;
      rsr8 = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rsr32 = (rm32 == 1) ? 1'b0 : (rm32 == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
         rsr8 = $urandom_range(0, 2) != 0;
      end
   end

   // called at a negedge; returns at the negedge following the accepting edge
   task automatic issue(input bit w8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int n;
      e = model(op, a, b, w8 ? 8 : 32);
      if (w8) begin
         rv8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      end else begin
         rv32 = 1'b1; op32 = op; a32 = a; b32 = b;
      end
      n = 0;
      while (!(w8 ? rr8 : rr32) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready stayed %0b, required 1", w8 ? rr8 : rr32);
         rv8 = 1'b0;
         rv32 = 1'b0;
         return;
      end
      e.acc_cyc = cyc + 1;
      if (w8) q8.push_back(e);
      else q32.push_back(e);
      @(posedge clk);
      #1;
      // scramble inputs after accept so late changes would corrupt a non-capturing design
      if (w8) begin
         rv8 = 1'b0; op8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      end else begin
         rv32 = 1'b0; op32 = 4'($urandom); a32 = $urandom; b32 = $urandom;
      end
      @(negedge clk);
   endtask

   task automatic drain(input bit w8);
      int n;
      n = 0;
      while (((w8 ? q8.size() : q32.size()) != 0 || (w8 ? rsv8 : rsv32)) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d responses still pending, required 0", w8 ? q8.size() : q32.size());
      end
   endtask

   task automatic rand_op(input bit w8);
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (op >= 4'hA && op <= 4'hC && $urandom_range(0, 3) == 0) b = $urandom_range(1, 15);
      if (op == 4'hA && $urandom_range(0, 1) == 0) begin
         a = $urandom_range(0, 65535);
         b = $urandom_range(0, 65535);
      end
      if (op >= 4'hB && op <= 4'hC && $urandom_range(0, 7) == 0) b = 0;
      if (w8 && (op == 4'hB || op == 4'hC) && $urandom_range(0, 7) == 0) b = 32'h100;
      issue(w8, op, a, b);
   endtask

   initial begin
      int n;
      seen[0] = 1'b0;
      seen[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(rr32), 64'd1);
      chk("rst_rsp_valid", 64'(rsv32), 64'd0);
      chk("rst_out", 64'(o32), 64'd0);
      chk("rst_flags", {62'b0, of32, dz32}, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      issue(0, 4'h4, 32'h7FFFFFFF, 32'h1);
      issue(0, 4'h6, 32'h80000000, 32'h1);
      issue(0, 4'h5, 32'hFFFFFFFF, 32'h1);
      issue(0, 4'hA, 32'h10000, 32'h10000);
      issue(0, 4'hA, 32'd1234, 32'd5678);
      issue(0, 4'hB, 32'd100, 32'd7);
      issue(0, 4'hC, 32'd100, 32'd7);
      issue(0, 4'hB, 32'd5, 32'd0);
      issue(0, 4'hC, 32'd5, 32'd0);
      issue(0, 4'h8, 32'h80000001, 32'h21);
      issue(0, 4'h9, 32'h00000003, 32'h1F);
      issue(0, 4'hF, 32'h12345678, 32'hFFFFFFFF);
      for (int i = 0; i < 80; i++) rand_op(0);
      drain(0);

      issue(1, 4'hB, 32'd200, 32'd3);
      issue(1, 4'hC, 32'd200, 32'd3);
      issue(1, 4'h9, 32'h81, 32'h1);
      issue(1, 4'hA, 32'hFF, 32'hFF);
      for (int i = 0; i < 60; i++) rand_op(1);
      drain(1);

      rm32 = 1;
      issue(0, 4'h3, 32'hA5A5A5A5, 32'h0F0F0F0F);
      n = 0;
      while (!rsv32 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      chk("hold_rsp_valid", 64'(rsv32), 64'd1);
      chk("hold_req_ready", 64'(rr32), 64'd0);
      rm32 = 2;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("release_req_ready", 64'(rr32), 64'd1);
      chk("release_rsp_valid", 64'(rsv32), 64'd0);
      rm32 = 0;
      drain(0);

      issue(0, 4'hB, $urandom, 32'($urandom_range(1, 1000)));
      repeat (9) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_req_ready", 64'(rr32), 64'd1);
      chk("abort_rsp_valid", 64'(rsv32), 64'd0);
      chk("abort_out", 64'(o32), 64'd0);
      chk("abort_flags", {62'b0, of32, dz32}, 64'd0);
      q32.delete();
      seen[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      issue(0, 4'h4, 32'h40000000, 32'h40000000);
      issue(0, 4'hC, 32'd1000, 32'd33);
      drain(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
